// File: rtl/moda_pkg.sv
// moda_pkg: shared definitions for the moda tally block.
//   CODE_*         2-bit compare codes produced by the moda comparator; the
//                  batch verdict uses the same encoding.
//   tally_state_t  batch FSM state: IDLE -> ACCUM -> DONE -> IDLE.
package moda_pkg;

  localparam logic [1:0] CODE_AGT = 2'd0;  // A > B
  localparam logic [1:0] CODE_ALT = 2'd1;  // A < B
  localparam logic [1:0] CODE_EQ  = 2'd2;  // A == B
  localparam logic [1:0] CODE_BAD = 2'd3;  // never legal from the comparator

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } tally_state_t;

endpackage

// File: rtl/tally_cnt.sv
// tally_cnt: CNT_W-bit up-counter with a synchronous clear and a count enable.
//   clk    rising-edge clock
//   rst_i  synchronous active-high reset, zeroes the count
//   clr_i  synchronous clear, wins over en_i
//   en_i   add one this cycle
//   cnt_o  current count
module tally_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state is written only with non-blocking assignments so every
  // register samples values from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moda_tally.sv
// moda_tally: counts a batch of ROUNDS compare codes from the moda comparator
// and emits the per-code tallies plus a batch verdict.
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; drops any batch in flight
//   start      opens a batch, honoured only in IDLE
//   in_valid / in_ready / in_code    code input stream (in_ready only in ACCUM)
//   out_valid / out_ready            result handshake (out_valid only in DONE)
//   cnt_a, cnt_b, cnt_eq             number of code 0 / 1 / 2 results
//   verdict    0: cnt_a>cnt_b, 1: cnt_a<cnt_b, 2: equal
//   err        sticky within a batch; set when code 3 is accepted
//   streak     longest run of identical non-tie codes; present only when the
//              macro MODA_TALLY_STREAK_EN is defined
// Results stay registered in IDLE until the next start.
module moda_tally
  import moda_pkg::*;
#(
  parameter  int ROUNDS = 16,
  localparam int CNT_W  = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [1:0]       verdict,
  output logic             err
`ifdef MODA_TALLY_STREAK_EN
  ,
  output logic [CNT_W-1:0] streak
`endif
);

  tally_state_t state_q, state_d;

  logic             open_batch;
  logic             accept;
  logic             last_accept;
  logic             en_a, en_b, en_eq;
  logic [CNT_W-1:0] cnt_rnd;
  logic [CNT_W-1:0] a_nxt, b_nxt;
  logic [1:0]       verdict_q, verdict_d;
  logic             err_q, err_d;

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign open_batch  = (state_q == IDLE) && start;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (cnt_rnd == CNT_W'(ROUNDS - 1));

  assign en_a  = accept && (in_code == CODE_AGT);
  assign en_b  = accept && (in_code == CODE_ALT);
  assign en_eq = accept && (in_code == CODE_EQ);

  // ---------------------------------------------------------------- FSM
  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)       state_d = ACCUM;
      ACCUM:   if (last_accept) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ------------------------------------------------------------ counters
  tally_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_i(rst), .clr_i(open_batch), .en_i(en_a), .cnt_o(cnt_a)
  );
  tally_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_i(rst), .clr_i(open_batch), .en_i(en_b), .cnt_o(cnt_b)
  );
  tally_cnt #(.CNT_W(CNT_W)) u_cnt_eq (
    .clk(clk), .rst_i(rst), .clr_i(open_batch), .en_i(en_eq), .cnt_o(cnt_eq)
  );
  // Round counter advances on every accept, including the illegal code 3.
  tally_cnt #(.CNT_W(CNT_W)) u_cnt_rnd (
    .clk(clk), .rst_i(rst), .clr_i(open_batch), .en_i(accept), .cnt_o(cnt_rnd)
  );

  // ------------------------------------------------------- verdict / err
  // The verdict is registered on the final accepting edge, so it must see
  // the counts including the code arriving on that same edge.
  assign a_nxt = cnt_a + CNT_W'(en_a);
  assign b_nxt = cnt_b + CNT_W'(en_b);

  always_comb begin
    verdict_d = verdict_q;
    err_d     = err_q;
    if (open_batch) begin
      err_d = 1'b0;
    end else if (accept && (in_code == CODE_BAD)) begin
      err_d = 1'b1;
    end
    if (last_accept) begin
      if (a_nxt > b_nxt)      verdict_d = CODE_AGT;
      else if (a_nxt < b_nxt) verdict_d = CODE_ALT;
      else                    verdict_d = CODE_EQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      verdict_q <= CODE_AGT;
      err_q     <= 1'b0;
    end else begin
      verdict_q <= verdict_d;
      err_q     <= err_d;
    end
  end

  assign verdict = verdict_q;
  assign err     = err_q;

`ifdef MODA_TALLY_STREAK_EN
  // ------------------------------------------------------- run tracking
  // last_q holds bit 0 of the last non-tie code (0 = A wins, 1 = B wins).
  // A tie or bad code zeroes the run, so the next non-tie code yields 1
  // whether or not it matches last_q.
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             last_q, last_d;

  always_comb begin
    run_d  = run_q;
    max_d  = max_q;
    last_d = last_q;
    if (open_batch) begin
      run_d  = '0;
      max_d  = '0;
      last_d = 1'b0;
    end else if (accept) begin
      if (in_code == CODE_AGT || in_code == CODE_ALT) begin
        run_d  = (in_code[0] == last_q) ? run_q + CNT_W'(1) : CNT_W'(1);
        last_d = in_code[0];
      end else begin
        run_d = '0;
      end
      if (run_d > max_q) max_d = run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      max_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      max_q  <= max_d;
      last_q <= last_d;
    end
  end

  assign streak = max_q;
`endif

endmodule
